// File: rtl/lm_sm_sequencer_pkg.sv
// Shared definitions for the LM/SM micro-op sequencer: opcodes, FSM states
// and the micro-op packing helper used by both the sequencer and decode.
package lm_sm_sequencer_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_LM_DEF = 4'b0110;
  localparam logic [OPC_W-1:0] OPC_SM_DEF = 4'b0111;
  localparam logic [OPC_W-1:0] OPC_LW_DEF = 4'b0100;
  localparam logic [OPC_W-1:0] OPC_SW_DEF = 4'b0101;

  // Widest supported instruction / field so the helper can serve any parameter set
  localparam int unsigned MAX_DATA_W  = 64;
  localparam int unsigned MAX_FIELD_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } seq_state_e;

  // Layout: {opc, rA, rB, offset}, MSB first; result is right-aligned in 64 bits.
  function automatic logic [MAX_DATA_W-1:0] pack_uop(
    input logic [OPC_W-1:0]       opc,
    input logic [MAX_FIELD_W-1:0] ra,
    input logic [MAX_FIELD_W-1:0] rb,
    input logic [MAX_FIELD_W-1:0] off,
    input int unsigned            reg_aw,
    input int unsigned            data_w
  );
    int unsigned            off_w;
    logic [MAX_DATA_W-1:0]  reg_m;
    logic [MAX_DATA_W-1:0]  off_m;
    logic [MAX_DATA_W-1:0]  word;
    off_w = data_w - OPC_W - 2 * reg_aw;
    reg_m = (64'd1 << reg_aw) - 64'd1;
    off_m = (64'd1 << off_w) - 64'd1;
    word  = ({60'd0, opc} << (data_w - OPC_W))
          | (({32'd0, ra} & reg_m) << (data_w - OPC_W - reg_aw))
          | (({32'd0, rb} & reg_m) << off_w)
          | ({32'd0, off} & off_m);
    return word;
  endfunction

endpackage

// File: rtl/lm_sm_sequencer_lsb.sv
// Lowest-set-bit finder: one-hot of the lowest set bit, its binary index,
// and a flag for an all-zero input vector.
module lsb_onehot_encoder #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [NREGS-1:0] vec_i,
  output logic [NREGS-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             zero_o
);

  assign onehot_o = vec_i & (~vec_i + NREGS'(1));
  assign zero_o   = (vec_i == '0);

  // Scan high to low so the lowest set bit wins the last assignment
  always_comb begin
    idx_o = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
      end else begin
        idx_o = idx_o;
      end
    end
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Load/store-multiple sequencer between fetch and IF/ID: expands LM/SM into
// one LW/SW per mask bit (lowest register first) and passes everything else through.
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
#(
  parameter int unsigned      DATA_W = 16,
  parameter int unsigned      NREGS  = 8,
  parameter int unsigned      REG_AW = 3,
  parameter logic [OPC_W-1:0] OPC_LM = OPC_LM_DEF,
  parameter logic [OPC_W-1:0] OPC_SM = OPC_SM_DEF,
  parameter logic [OPC_W-1:0] OPC_LW = OPC_LW_DEF,
  parameter logic [OPC_W-1:0] OPC_SW = OPC_SW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ir_in,
  input  logic              ir_valid,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_out_valid,
  output logic              hold_fetch,
  output logic              first_multiple,
  output logic              last_multiple,
  output logic              busy
);

  localparam int OFF_W = int'(DATA_W) - int'(OPC_W) - 2 * int'(REG_AW);
  localparam int unsigned OFF_WU = (OFF_W > 0) ? OFF_W : 1;

  if (REG_AW < $clog2(NREGS)) begin : g_bad_reg_aw
    $error("REG_AW too narrow to address NREGS registers");
  end
  if (OFF_W < 1 || (64'd1 << OFF_WU) < 64'(NREGS)) begin : g_bad_off_w
    $error("offset field cannot hold NREGS-1");
  end
  if (DATA_W > MAX_DATA_W || REG_AW > MAX_FIELD_W || OFF_WU > MAX_FIELD_W) begin : g_bad_width
    $error("field widths exceed packing helper limits");
  end

  seq_state_e        state_q, state_d;
  logic [NREGS-1:0]  rem_mask_q, rem_mask_d;
  logic [OFF_WU-1:0] k_q, k_d;
  logic [REG_AW-1:0] base_q, base_d;
  logic              is_store_q, is_store_d;

  logic [OPC_W-1:0]  opc_s;
  logic [REG_AW-1:0] base_in_s;
  logic [NREGS-1:0]  mask_in_s;
  logic              is_lmsm_s;
  logic              in_seq_s;
  logic [NREGS-1:0]  src_mask_s;
  logic [NREGS-1:0]  lsb_oh_s;
  logic [REG_AW-1:0] lsb_idx_s;
  logic              lsb_zero_s;
  logic [NREGS-1:0]  rest_s;
  logic              uop_store_s;
  logic [REG_AW-1:0] uop_base_s;
  logic [OFF_WU-1:0] uop_k_s;
  logic [DATA_W-1:0] uop_s;

  logic [DATA_W-1:0] ir_out_c;
  logic              valid_c;
  logic              hold_c;
  logic              first_c;
  logic              last_c;

  assign opc_s     = ir_in[DATA_W-1 -: OPC_W];
  assign base_in_s = ir_in[DATA_W-OPC_W-1 -: REG_AW];
  assign mask_in_s = ir_in[NREGS-1:0];
  assign is_lmsm_s = ir_valid && ((opc_s == OPC_LM) || (opc_s == OPC_SM));
  assign in_seq_s  = (state_q == ST_SEQ);

  // In SEQ the encoder works on the captured remainder, otherwise on the fresh mask
  assign src_mask_s = in_seq_s ? rem_mask_q : mask_in_s;
  assign rest_s     = src_mask_s & ~lsb_oh_s;

  lsb_onehot_encoder #(
    .NREGS (NREGS),
    .IDX_W (REG_AW)
  ) u_lsb (
    .vec_i    (src_mask_s),
    .onehot_o (lsb_oh_s),
    .idx_o    (lsb_idx_s),
    .zero_o   (lsb_zero_s)
  );

  assign uop_store_s = in_seq_s ? is_store_q : (opc_s == OPC_SM);
  assign uop_base_s  = in_seq_s ? base_q : base_in_s;
  assign uop_k_s     = in_seq_s ? k_q : '0;
  assign uop_s       = DATA_W'(pack_uop(uop_store_s ? OPC_SW : OPC_LW,
                                        32'(lsb_idx_s), 32'(uop_base_s),
                                        32'(uop_k_s), REG_AW, DATA_W));

  // Next-state and output decode; outputs are combinational so pass-through has no latency
  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    k_d        = k_q;
    base_d     = base_q;
    is_store_d = is_store_q;
    ir_out_c   = '0;
    valid_c    = 1'b0;
    hold_c     = 1'b0;
    first_c    = 1'b0;
    last_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!is_lmsm_s) begin
          ir_out_c = ir_in;
          valid_c  = ir_valid;
        end else if (lsb_zero_s) begin
          valid_c = 1'b0;
        end else begin
          ir_out_c = uop_s;
          valid_c  = 1'b1;
          first_c  = 1'b1;
          if (rest_s == '0) begin
            last_c = 1'b1;
          end else begin
            hold_c = 1'b1;
            if (!stall) begin
              state_d    = ST_SEQ;
              rem_mask_d = rest_s;
              k_d        = OFF_WU'(1);
              base_d     = base_in_s;
              is_store_d = (opc_s == OPC_SM);
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_SEQ: begin
        ir_out_c = uop_s;
        valid_c  = 1'b1;
        if (rest_s == '0) begin
          last_c = 1'b1;
          if (!stall) begin
            state_d    = ST_IDLE;
            rem_mask_d = '0;
            k_d        = '0;
          end else begin
            state_d = ST_SEQ;
          end
        end else begin
          hold_c = 1'b1;
          if (!stall) begin
            rem_mask_d = rest_s;
            k_d        = k_q + OFF_WU'(1);
          end else begin
            rem_mask_d = rem_mask_q;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        rem_mask_d = '0;
        k_d        = '0;
      end
    endcase

    // Flush overrides everything, including stall
    if (flush) begin
      valid_c    = 1'b0;
      hold_c     = 1'b0;
      first_c    = 1'b0;
      last_c     = 1'b0;
      state_d    = ST_IDLE;
      rem_mask_d = '0;
      k_d        = '0;
    end else begin
      valid_c = valid_c;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rem_mask_q <= '0;
      k_q        <= '0;
      base_q     <= '0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
      k_q        <= k_d;
      base_q     <= base_d;
      is_store_q <= is_store_d;
    end
  end

  assign ir_out         = reset ? '0   : ir_out_c;
  assign ir_out_valid   = reset ? 1'b0 : valid_c;
  assign hold_fetch     = reset ? 1'b0 : hold_c;
  assign first_multiple = reset ? 1'b0 : first_c;
  assign last_multiple  = reset ? 1'b0 : last_c;
  assign busy           = reset ? 1'b0 : in_seq_s;

endmodule
